// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game states and sprite geometry defaults
package game_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PLAY   = 2'd1,
      INVULN = 2'd2,
      OVER   = 2'd3
   } state_e;

   localparam int SCREEN_H_DFLT     = 480;
   localparam int PLANE_X_DFLT      = 60;
   localparam int PLANE_W_DFLT      = 32;
   localparam int PLANE_H_DFLT      = 16;
   localparam int LAVA_W_DFLT       = 8;
   localparam int LAVA_H_DFLT       = 8;
   localparam int MTN_W_DFLT        = 40;
   localparam int LIVES_DFLT        = 3;
   localparam int INVULN_TICKS_DFLT = 30;

endpackage

// File: rtl/collision_ctrl_if.sv
// rtl/collision_ctrl_if.sv - frame tick, positions and game status bundle
interface collision_ctrl_if;
   import game_pkg::*;

   logic        tick;
   logic        start;
   logic [9:0]  plane_y;
   logic [9:0]  lava_x;
   logic [9:0]  lava_y;
   logic [9:0]  mountain1_x;
   logic [9:0]  mountain1_y;
   logic [9:0]  mountain2_x;
   logic [9:0]  mountain2_y;
   logic        game_over;
   logic        hit;
   logic [1:0]  lives;
   state_e      state;
   logic [15:0] survive_ticks;

   modport slave (
      input  tick, start, plane_y, lava_x, lava_y,
             mountain1_x, mountain1_y, mountain2_x, mountain2_y,
      output game_over, hit, lives, state, survive_ticks
   );

   modport master (
      output tick, start, plane_y, lava_x, lava_y,
             mountain1_x, mountain1_y, mountain2_x, mountain2_y,
      input  game_over, hit, lives, state, survive_ticks
   );

endinterface

// File: rtl/box_overlap.sv
// rtl/box_overlap.sv - half-open box intersection test on 11-bit coordinates
module box_overlap (
   input  logic [10:0] a_x0_i,
   input  logic [10:0] a_x1_i,
   input  logic [10:0] a_y0_i,
   input  logic [10:0] a_y1_i,
   input  logic [10:0] b_x0_i,
   input  logic [10:0] b_x1_i,
   input  logic [10:0] b_y0_i,
   input  logic [10:0] b_y1_i,
   output logic        overlap_o
);

   assign overlap_o = (a_x0_i < b_x1_i) && (b_x0_i < a_x1_i) &&
                      (a_y0_i < b_y1_i) && (b_y0_i < a_y1_i);

endmodule

// File: rtl/collision_ctrl.sv
// rtl/collision_ctrl.sv - per-frame collision check, lives and invulnerability FSM
module collision_ctrl #(
   parameter int PLANE_X      = game_pkg::PLANE_X_DFLT,
   parameter int PLANE_W      = game_pkg::PLANE_W_DFLT,
   parameter int PLANE_H      = game_pkg::PLANE_H_DFLT,
   parameter int LAVA_W       = game_pkg::LAVA_W_DFLT,
   parameter int LAVA_H       = game_pkg::LAVA_H_DFLT,
   parameter int MTN_W        = game_pkg::MTN_W_DFLT,
   parameter int SCREEN_H     = game_pkg::SCREEN_H_DFLT,
   parameter int LIVES        = game_pkg::LIVES_DFLT,
   parameter int INVULN_TICKS = game_pkg::INVULN_TICKS_DFLT
) (
   input  logic             clk,
   input  logic             reset,
   collision_ctrl_if.slave  bus
);
   import game_pkg::*;

   logic [10:0] px0, px1, py0, py1;
   logic [10:0] lx0, lx1, ly0, ly1;
   logic [10:0] m1x0, m1x1, m1y0, m2x0, m2x1, m2y0, mtn_y1;
   logic        hit_lava, hit_m1, hit_m2, collide;

   assign px0    = 11'(PLANE_X);
   assign px1    = 11'(PLANE_X + PLANE_W);
   assign py0    = {1'b0, bus.plane_y};
   assign py1    = py0 + 11'(PLANE_H);
   assign lx0    = {1'b0, bus.lava_x};
   assign lx1    = lx0 + 11'(LAVA_W);
   assign ly0    = {1'b0, bus.lava_y};
   assign ly1    = ly0 + 11'(LAVA_H);
   assign m1x0   = {1'b0, bus.mountain1_x};
   assign m1x1   = m1x0 + 11'(MTN_W);
   assign m1y0   = {1'b0, bus.mountain1_y};
   assign m2x0   = {1'b0, bus.mountain2_x};
   assign m2x1   = m2x0 + 11'(MTN_W);
   assign m2y0   = {1'b0, bus.mountain2_y};
   assign mtn_y1 = 11'(SCREEN_H);

   box_overlap u_lava (.a_x0_i(px0), .a_x1_i(px1), .a_y0_i(py0), .a_y1_i(py1),
                       .b_x0_i(lx0), .b_x1_i(lx1), .b_y0_i(ly0), .b_y1_i(ly1),
                       .overlap_o(hit_lava));
   box_overlap u_mtn1 (.a_x0_i(px0), .a_x1_i(px1), .a_y0_i(py0), .a_y1_i(py1),
                       .b_x0_i(m1x0), .b_x1_i(m1x1), .b_y0_i(m1y0), .b_y1_i(mtn_y1),
                       .overlap_o(hit_m1));
   box_overlap u_mtn2 (.a_x0_i(px0), .a_x1_i(px1), .a_y0_i(py0), .a_y1_i(py1),
                       .b_x0_i(m2x0), .b_x1_i(m2x1), .b_y0_i(m2y0), .b_y1_i(mtn_y1),
                       .overlap_o(hit_m2));

   assign collide = hit_lava | hit_m1 | hit_m2;

   state_e      state_q, state_d;
   logic [1:0]  lives_q, lives_d;
   logic [15:0] surv_q, surv_d, surv_inc;
   logic [7:0]  inv_q, inv_d;
   logic        hit_q, hit_d;
   logic        go_q, go_d;

   assign surv_inc = (surv_q == 16'hFFFF) ? surv_q : surv_q + 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         lives_q <= 2'(LIVES);
         surv_q  <= 16'd0;
         inv_q   <= 8'd0;
         hit_q   <= 1'b0;
         go_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         lives_q <= lives_d;
         surv_q  <= surv_d;
         inv_q   <= inv_d;
         hit_q   <= hit_d;
         go_q    <= go_d;
      end
   end

   // A start in IDLE/OVER wins over a coincident tick: no count, no collision check.
   always_comb begin
      state_d = state_q;
      lives_d = lives_q;
      surv_d  = surv_q;
      inv_d   = inv_q;
      hit_d   = 1'b0;
      go_d    = go_q;
      case (state_q)
         IDLE, OVER: begin
            if (bus.start) begin
               state_d = PLAY;
               lives_d = 2'(LIVES);
               surv_d  = 16'd0;
               go_d    = 1'b0;
            end
         end
         PLAY: begin
            if (bus.tick) begin
               surv_d = surv_inc;
               if (collide) begin
                  hit_d   = 1'b1;
                  lives_d = lives_q - 2'd1;
                  if (lives_q == 2'd1) begin
                     state_d = OVER;
                     go_d    = 1'b1;
                  end else begin
                     state_d = INVULN;
                     inv_d   = 8'(INVULN_TICKS);
                  end
               end
            end
         end
         INVULN: begin
            if (bus.tick) begin
               surv_d = surv_inc;
               inv_d  = inv_q - 8'd1;
               if (inv_q == 8'd1) state_d = PLAY;
            end
         end
         default: ;
      endcase
   end

   assign bus.game_over     = go_q;
   assign bus.hit           = hit_q;
   assign bus.lives         = lives_q;
   assign bus.state         = state_q;
   assign bus.survive_ticks = surv_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// tb/tb_collision_ctrl.sv - scoreboard bench for collision_ctrl
module tb_collision_ctrl;
   import game_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;

   collision_ctrl_if bus();

   collision_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [1:0]  st;
      logic        go;
      logic [1:0]  lv;
      logic [15:0] sv;
      logic        h;
      int          nh;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_checks  = 0;
   int   n_fail    = 0;
   int   hit_total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   // Monitor: counts hit pulses and checks every queued expectation mid-cycle.
   always @(negedge clk) begin
      if (reset) hit_total = 0;
      else if (bus.hit === 1'b1) hit_total++;
      while (exp_q.size() > 0) begin
         cur = exp_q.pop_front();
         chk({cur.name, ".state"},     32'(bus.state),         32'(cur.st));
         chk({cur.name, ".game_over"}, 32'(bus.game_over),     32'(cur.go));
         chk({cur.name, ".lives"},     32'(bus.lives),         32'(cur.lv));
         chk({cur.name, ".survive"},   32'(bus.survive_ticks), 32'(cur.sv));
         chk({cur.name, ".hit"},       32'(bus.hit),           32'(cur.h));
         chk({cur.name, ".hit_count"}, 32'(hit_total),         32'(cur.nh));
      end
   end

   task automatic expect_o(input string nm, input logic [1:0] st, input logic go,
                           input logic [1:0] lv, input logic [15:0] sv, input logic h,
                           input int nh);
      exp_t e;
      e.name = nm; e.st = st; e.go = go; e.lv = lv; e.sv = sv; e.h = h; e.nh = nh;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input logic t, input logic s);
      bus.tick  = t;
      bus.start = s;
      @(posedge clk);
      #1;
      bus.tick  = 1'b0;
      bus.start = 1'b0;
   endtask

   task automatic tk(input string nm, input logic [1:0] st, input logic go,
                     input logic [1:0] lv, input logic [15:0] sv, input logic h,
                     input int nh);
      cyc(1'b1, 1'b0);
      expect_o(nm, st, go, lv, sv, h, nh);
      cyc(1'b0, 1'b0);
   endtask

   task automatic set_pos(input logic [9:0] py, input logic [9:0] lx, input logic [9:0] ly,
                          input logic [9:0] m1x, input logic [9:0] m1y,
                          input logic [9:0] m2x, input logic [9:0] m2y);
      bus.plane_y = py;
      bus.lava_x = lx; bus.lava_y = ly;
      bus.mountain1_x = m1x; bus.mountain1_y = m1y;
      bus.mountain2_x = m2x; bus.mountain2_y = m2y;
   endtask

   initial begin
      int waitc;
      bus.tick  = 1'b0;
      bus.start = 1'b0;
      set_pos(10'd100, 10'd300, 10'd300, 10'd300, 10'd150, 10'd500, 10'd150);
      repeat (2) @(posedge clk);
      #1;
      expect_o("reset", IDLE, 1'b1, 2'd3, 16'd0, 1'b0, 0);
      cyc(1'b0, 1'b0);
      reset = 1'b0;

      cyc(1'b0, 1'b1);
      expect_o("start", PLAY, 1'b0, 2'd3, 16'd0, 1'b0, 0);
      cyc(1'b0, 1'b0);
      for (int i = 1; i <= 5; i++)
         tk($sformatf("free%0d", i), PLAY, 1'b0, 2'd3, 16'(i), 1'b0, 0);

      set_pos(10'd100, 10'd70, 10'd105, 10'd300, 10'd150, 10'd500, 10'd150);
      tk("hit1", INVULN, 1'b0, 2'd2, 16'd6, 1'b1, 1);
      expect_o("hit1_drop", INVULN, 1'b0, 2'd2, 16'd6, 1'b0, 1);
      for (int i = 1; i <= 29; i++)
         tk($sformatf("inv%0d", i), INVULN, 1'b0, 2'd2, 16'(6 + i), 1'b0, 1);
      tk("inv_end", PLAY, 1'b0, 2'd2, 16'd36, 1'b0, 1);
      tk("hit2", INVULN, 1'b0, 2'd1, 16'd37, 1'b1, 2);

      set_pos(10'd100, 10'd300, 10'd300, 10'd300, 10'd150, 10'd500, 10'd150);
      for (int i = 1; i <= 29; i++)
         tk($sformatf("inv2_%0d", i), INVULN, 1'b0, 2'd1, 16'(37 + i), 1'b0, 2);
      tk("inv2_end", PLAY, 1'b0, 2'd1, 16'd67, 1'b0, 2);

      set_pos(10'd100, 10'd92, 10'd100, 10'd300, 10'd150, 10'd500, 10'd150);
      tk("lava_edge", PLAY, 1'b0, 2'd1, 16'd68, 1'b0, 2);
      set_pos(10'd94, 10'd300, 10'd300, 10'd80, 10'd110, 10'd500, 10'd150);
      tk("mtn_edge", PLAY, 1'b0, 2'd1, 16'd69, 1'b0, 2);
      set_pos(10'd95, 10'd300, 10'd300, 10'd80, 10'd110, 10'd500, 10'd150);
      tk("hit3", OVER, 1'b1, 2'd0, 16'd70, 1'b1, 3);
      tk("over_a", OVER, 1'b1, 2'd0, 16'd70, 1'b0, 3);
      tk("over_b", OVER, 1'b1, 2'd0, 16'd70, 1'b0, 3);

      cyc(1'b1, 1'b1);
      expect_o("restart", PLAY, 1'b0, 2'd3, 16'd0, 1'b0, 3);
      cyc(1'b0, 1'b0);

      set_pos(10'd100, 10'd70, 10'd105, 10'd80, 10'd110, 10'd60, 10'd100);
      tk("multi", INVULN, 1'b0, 2'd2, 16'd1, 1'b1, 4);
      expect_o("multi_drop", INVULN, 1'b0, 2'd2, 16'd1, 1'b0, 4);
      cyc(1'b0, 1'b1);
      expect_o("start_inv", INVULN, 1'b0, 2'd2, 16'd1, 1'b0, 4);
      cyc(1'b0, 1'b0);

      reset = 1'b1;
      expect_o("async_rst", IDLE, 1'b1, 2'd3, 16'd0, 1'b0, 0);
      @(negedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;

      set_pos(10'd100, 10'd300, 10'd300, 10'd300, 10'd150, 10'd500, 10'd150);
      cyc(1'b0, 1'b1);
      expect_o("start2", PLAY, 1'b0, 2'd3, 16'd0, 1'b0, 0);
      cyc(1'b0, 1'b0);
      cyc(1'b0, 1'b1);
      expect_o("start_play", PLAY, 1'b0, 2'd3, 16'd0, 1'b0, 0);
      cyc(1'b0, 1'b0);
      tk("post", PLAY, 1'b0, 2'd3, 16'd1, 1'b0, 0);

      waitc = 0;
      while (exp_q.size() > 0 && waitc < 10) begin
         @(negedge clk);
         waitc++;
      end
      #1;
      if (exp_q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
